// File: rtl/k_fifo2_arb_ctrl_pkg.sv
// Shared types and constants for the two-producer, 2-entry FIFO controller.
package k_fifo_pkg;
  localparam int FIFO_DEPTH = 2;
  typedef logic [1:0] fifo_cnt_t;
  typedef enum logic {SRC0, SRC1} src_t;
endpackage

// File: rtl/k_dp_2deep_ram_t1.sv
// Small dual-port RAM: registered write, combinational read.
module k_dp_2deep_ram_t1 #(
  parameter int data_size = 8,
  parameter int addr_size = 1
) (
  input  logic                 clk,
  input  logic                 wen,
  input  logic [addr_size-1:0] waddr,
  input  logic [data_size-1:0] d,
  input  logic [addr_size-1:0] raddr,
  output logic [data_size-1:0] q
);
  localparam int DEPTH = 1 << addr_size;

  logic [data_size-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wen) mem[waddr] <= d;
  end

  assign q = mem[raddr];
endmodule

// File: rtl/k_fifo2_arb_ctrl_arb.sv
// Two-way round-robin arbiter; history only advances when a grant is accepted.
module k_rr_arb2
  import k_fifo_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);
  src_t last_gnt;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_gnt == SRC1) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // A stalled requester keeps its turn because history only moves on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      last_gnt <= SRC1;
    else if (accept) last_gnt <= src_t'(gnt[1]);
  end
endmodule

// File: rtl/k_fifo2_arb_ctrl.sv
// Turns a 2-deep dual-port RAM into a 2-entry FIFO shared by two producers,
// storing a source tag with each payload.
module k_fifo2_arb_ctrl
  import k_fifo_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid_0,
  input  logic [DW-1:0] in_data_0,
  output logic          in_ready_0,
  input  logic          in_valid_1,
  input  logic [DW-1:0] in_data_1,
  output logic          in_ready_1,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_src,
  input  logic          out_ready,
  output logic [1:0]    count
);
  logic      wptr, rptr;
  fifo_cnt_t cnt;
  logic      full, empty;
  logic [1:0] gnt;
  src_t      g;
  logic      push, pop;
  logic      wen, waddr, raddr;
  logic [DW:0] wdata, rdata;

  assign full  = (cnt == fifo_cnt_t'(FIFO_DEPTH));
  assign empty = (cnt == 2'd0);

  k_rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    ({in_valid_1, in_valid_0}),
    .accept (push),
    .gnt    (gnt)
  );

  // Full blocks writes even when a pop happens the same cycle: no write-through.
  assign in_ready_0 = gnt[0] & ~full & ~flush;
  assign in_ready_1 = gnt[1] & ~full & ~flush;

  assign g     = src_t'(gnt[1]);
  assign push  = (in_valid_0 & in_ready_0) | (in_valid_1 & in_ready_1);
  assign wdata = (g == SRC1) ? {1'b1, in_data_1} : {1'b0, in_data_0};

  assign wen   = push;
  assign waddr = wptr;
  assign raddr = rptr;

  k_dp_2deep_ram_t1 #(.data_size(DW + 1), .addr_size(1)) u_ram (
    .clk   (clk),
    .wen   (wen),
    .waddr (waddr),
    .d     (wdata),
    .raddr (raddr),
    .q     (rdata)
  );

  assign out_valid           = ~empty;
  assign {out_src, out_data} = rdata;
  assign pop                 = out_valid & out_ready & ~flush;
  assign count               = cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= 1'b0;
      rptr <= 1'b0;
      cnt  <= 2'd0;
    end else if (flush) begin
      wptr <= 1'b0;
      rptr <= 1'b0;
      cnt  <= 2'd0;
    end else begin
      if (push) wptr <= ~wptr;
      if (pop)  rptr <= ~rptr;
      case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  a_cnt_bound: assert property (@(posedge clk) disable iff (!rst_n)
    cnt <= fifo_cnt_t'(FIFO_DEPTH));
endmodule
